tm_controller: RTL and testbench

Sequencing controller for the 8-cell, 2-bit-symbol `tape` storage. It holds a programmable transition table and runs a Turing-machine step loop against the tape: read the symbol under the head, look up the rule, write the new symbol, move the head, and update the state. It stops on a halt state, an undefined rule, a head-edge fault or a step limit. It sits between the top-level control (start/program ports) and the `tape` instance, and owns the tape's `mode`, `head` and `in` pins.

---
 rtl/tm_controller_if.sv | 29 ++
 rtl/tm_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_tm_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_controller_if.sv
// -----------------------------------------------------------------------------
// tm_controller_if
// Pin bundle between tm_controller and the 8-cell, 2-bit-symbol tape storage.
//   tape_mode : 0 = read (tape registers out from cell[head]), 1 = write
//   tape_head : cell index 0..7
//   tape_in   : symbol written when tape_mode = 1
//   tape_out  : registered symbol returned by the tape
// master = controller side, slave = tape side.
// -----------------------------------------------------------------------------
interface tm_controller_if;
   logic       tape_mode;
   logic [2:0] tape_head;
   logic [1:0] tape_in;
   logic [1:0] tape_out;

   modport master (
      output tape_mode,
      output tape_head,
      output tape_in,
      input  tape_out
   );

   modport slave (
      input  tape_mode,
      input  tape_head,
      input  tape_in,
      output tape_out
   );
endinterface

// File: rtl/tm_controller.sv
// -----------------------------------------------------------------------------
// tm_controller
// Turing-machine step sequencer for the 8-cell tape. Holds a programmable
// transition table and runs READ -> LOOKUP -> WRITE -> MOVE per step until a
// halt state, an undefined rule, a head-edge fault or the step budget ends the
// run.
//
// Ports
//   clk, reset         : clock, asynchronous active-low reset
//   start, start_head  : run request (ignored while busy) and initial head
//   prog_we/addr/data  : table write; addr = {state, symbol}, symbol 11 == 10;
//                        data = {valid, next_state, write_sym, move}
//   tape               : tm_controller_if.master, tape mode/head/in/out pins
//   busy, done, error  : run status; error 00 ok, 01 undefined rule,
//                        10 head off edge, 11 step limit
//   cur_state, steps   : current machine state, completed step count
//
// Build option: define TM_WRAP_EN to make head moves wrap modulo 8 instead
// of faulting at the tape edges.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_READ   | tape_mode=0, head stable; tape registers cell[head]
// S_LOOKUP | sample tape_out, fetch rule {cur_state, symbol}
// S_WRITE  | tape_mode=1, tape_in=write_sym for exactly one cycle
// S_MOVE   | move head, update cur_state/steps, decide end of run
// S_DONE   | run finished, outputs held, start re-launches
// -----------------------------------------------------------------------------
module tm_controller #(
   parameter int STATE_W     = 2,
   parameter int START_STATE = 0,
   parameter int HALT_STATE  = 3,
   parameter int MAX_STEPS   = 255,
   parameter int STEP_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           start_head,
   input  logic                 prog_we,
   input  logic [STATE_W+1:0]   prog_addr,
   input  logic [STATE_W+4:0]   prog_data,
   tm_controller_if.master      tape,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           error,
   output logic [STATE_W-1:0]   cur_state,
   output logic [STEP_W-1:0]    steps
);

   localparam int N_RULES = (2 ** STATE_W) * 3;
   localparam int IDX_W   = $clog2(N_RULES);

   localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);
   localparam logic [STATE_W-1:0] HALT_S  = STATE_W'(HALT_STATE);
   localparam logic [STEP_W-1:0]  MAX_S   = STEP_W'(MAX_STEPS);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_UNDEF = 2'b01;
   localparam logic [1:0] ERR_EDGE  = 2'b10;
   localparam logic [1:0] ERR_LIMIT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOOKUP,
      S_WRITE,
      S_MOVE,
      S_DONE
   } state_t;

   // Rule index = state*3 + symbol index, with both blank encodings on 2.
   function automatic logic [IDX_W-1:0] rule_idx(input logic [STATE_W-1:0] st,
                                                 input logic [1:0]         sym);
      return IDX_W'(st) * IDX_W'(3) + (sym[1] ? IDX_W'(2) : IDX_W'(sym));
   endfunction

   logic [STATE_W+4:0] tbl [N_RULES];

   state_t             state_q, state_nxt;
   logic [2:0]         head_q, head_nxt;
   logic [STATE_W-1:0] cur_q, cur_nxt;
   logic [STEP_W-1:0]  steps_q, steps_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic [1:0]         err_q, err_nxt;
   logic               mode_q, mode_nxt;
   logic [1:0]         tin_q, tin_nxt;
   logic [STATE_W-1:0] rnext_q, rnext_nxt;
   logic [1:0]         rmove_q, rmove_nxt;

   logic [STATE_W+4:0] lookup_rule;
   logic [2:0]         move_head;
   logic               edge_fault;
   logic [STEP_W-1:0]  steps_inc;

   assign lookup_rule = tbl[rule_idx(cur_q, tape.tape_out)];
   assign steps_inc   = steps_q + STEP_W'(1);

   // Table writes are blocked for the whole run so a step never sees a rule
   // change underneath it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_RULES; i++) tbl[i] <= '0;
      end else if (prog_we && !busy_q) begin
         tbl[rule_idx(prog_addr[STATE_W+1:2], prog_addr[1:0])] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         head_q  <= 3'd0;
         cur_q   <= START_S;
         steps_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= ERR_OK;
         mode_q  <= 1'b0;
         tin_q   <= 2'b10;
         rnext_q <= '0;
         rmove_q <= 2'b00;
      end else begin
         state_q <= state_nxt;
         head_q  <= head_nxt;
         cur_q   <= cur_nxt;
         steps_q <= steps_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
         mode_q  <= mode_nxt;
         tin_q   <= tin_nxt;
         rnext_q <= rnext_nxt;
         rmove_q <= rmove_nxt;
      end
   end

   // Head update for the latched move code.
   always_comb begin
      move_head  = head_q;
      edge_fault = 1'b0;
      case (rmove_q)
         2'b01: begin
`ifdef TM_WRAP_EN
            move_head = head_q + 3'd1;
`else
            if (head_q == 3'd7) edge_fault = 1'b1;
            else                move_head  = head_q + 3'd1;
`endif
         end
         2'b10: begin
`ifdef TM_WRAP_EN
            move_head = head_q - 3'd1;
`else
            if (head_q == 3'd0) edge_fault = 1'b1;
            else                move_head  = head_q - 3'd1;
`endif
         end
         default: move_head = head_q;
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      head_nxt  = head_q;
      cur_nxt   = cur_q;
      steps_nxt = steps_q;
      busy_nxt  = busy_q;
      done_nxt  = done_q;
      err_nxt   = err_q;
      tin_nxt   = tin_q;
      rnext_nxt = rnext_q;
      rmove_nxt = rmove_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               head_nxt  = start_head;
               cur_nxt   = START_S;
               steps_nxt = '0;
               err_nxt   = ERR_OK;
               done_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = S_READ;
            end
         end
         S_READ: state_nxt = S_LOOKUP;
         S_LOOKUP: begin
            if (!lookup_rule[STATE_W+4]) begin
               err_nxt   = ERR_UNDEF;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = S_DONE;
            end else begin
               rnext_nxt = lookup_rule[STATE_W+3:4];
               tin_nxt   = lookup_rule[3:2];
               rmove_nxt = lookup_rule[1:0];
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: state_nxt = S_MOVE;
         S_MOVE: begin
            head_nxt  = move_head;
            cur_nxt   = rnext_q;
            steps_nxt = steps_inc;
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            // Halt wins over an edge fault on the same step, which wins over
            // running out of budget.
            if (rnext_q == HALT_S) begin
               err_nxt = ERR_OK;
            end else if (edge_fault) begin
               err_nxt = ERR_EDGE;
            end else if (steps_inc == MAX_S) begin
               err_nxt = ERR_LIMIT;
            end else begin
               state_nxt = S_READ;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Registered so tape_mode is high exactly for the WRITE cycle.
      mode_nxt = (state_nxt == S_WRITE);
   end

   assign tape.tape_mode = mode_q;
   assign tape.tape_head = head_q;
   assign tape.tape_in   = tin_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = err_q;
   assign cur_state      = cur_q;
   assign steps          = steps_q;

endmodule

// File: tb/tb_tm_controller.sv
module tb_tm_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] start_head;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [6:0] prog_data;
   logic       busy;
   logic       done;
   logic [1:0] error;
   logic [1:0] cur_state;
   logic [7:0] steps;

   tm_controller_if tape_bus();

   tm_controller dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_head (start_head),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .tape       (tape_bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .cur_state  (cur_state),
      .steps      (steps)
   );

   always #5 clk = ~clk;

   // Behavioural tape: registered read when mode=0, cell write when mode=1.
   logic [1:0] cells     [8];
   logic [1:0] pre_cells [8];
   logic       pre_load;
   logic [1:0] tape_out_q = 2'b10;
   assign tape_bus.tape_out = tape_out_q;

   always @(posedge clk) begin
      if (pre_load) begin
         for (int i = 0; i < 8; i++) cells[i] <= pre_cells[i];
      end else if (tape_bus.tape_mode) begin
         cells[tape_bus.tape_head] <= tape_bus.tape_in;
      end else begin
         tape_out_q <= cells[tape_bus.tape_head];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bench mirror of the rule table and reference machine.
   logic [6:0] ref_tbl [12];

   typedef struct {
      int          latency;
      int          err;
      int          steps;
      int          head;
      int          st;
      int          writes;
      logic [15:0] tape;
   } exp_t;

   exp_t sb_q[$];

   function automatic int ridx(input logic [3:0] a);
      return int'(a[3:2]) * 3 + (a[1] ? 2 : int'(a[1:0]));
   endfunction

   function automatic exp_t model_run(input logic [2:0] sh);
      exp_t       e;
      logic [1:0] t [8];
      logic [6:0] r;
      int         head, st, n, err, writes, idx, nh;
      bit         stop, fault;
      for (int i = 0; i < 8; i++) t[i] = pre_cells[i];
      head = int'(sh); st = 0; n = 0; err = 0; writes = 0; stop = 0;
      while (!stop) begin
         idx = st * 3 + (t[head][1] ? 2 : int'(t[head]));
         r   = ref_tbl[idx];
         if (!r[6]) begin
            err  = 1;
            stop = 1;
         end else begin
            t[head] = r[3:2];
            writes++;
            fault = 0;
            nh    = head;
            if (r[1:0] == 2'b01)      nh = head + 1;
            else if (r[1:0] == 2'b10) nh = head - 1;
`ifdef TM_WRAP_EN
            nh = (nh + 8) % 8;
`else
            if (nh < 0 || nh > 7) begin
               fault = 1;
               nh    = head;
            end
`endif
            head = nh;
            st   = int'(r[5:4]);
            n++;
            if (st == 3)        stop = 1;
            else if (fault)     begin err = 2; stop = 1; end
            else if (n == 255)  begin err = 3; stop = 1; end
         end
      end
      e.latency = (err == 1) ? 4 * n + 3 : 4 * n + 1;
      e.err     = err;
      e.steps   = n;
      e.head    = head;
      e.st      = st;
      e.writes  = writes;
      for (int i = 0; i < 8; i++) e.tape[2*i +: 2] = t[i];
      return e;
   endfunction

   task automatic clear_ref();
      for (int i = 0; i < 12; i++) ref_tbl[i] = 7'd0;
   endtask

   task automatic load_tape(input logic [15:0] pat);
      for (int i = 0; i < 8; i++) pre_cells[i] = pat[2*i +: 2];
      @(negedge clk);
      pre_load = 1'b1;
      @(posedge clk);
      #1 pre_load = 1'b0;
   endtask

   task automatic prog(input logic [3:0] a, input logic [6:0] d);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      ref_tbl[ridx(a)] = d;
      @(posedge clk);
      #1 prog_we = 1'b0;
   endtask

   task automatic check_reset_vals();
      check_val("rst_mode",  32'(tape_bus.tape_mode), 32'd0);
      check_val("rst_head",  32'(tape_bus.tape_head), 32'd0);
      check_val("rst_in",    32'(tape_bus.tape_in),   32'd2);
      check_val("rst_busy",  32'(busy),      32'd0);
      check_val("rst_done",  32'(done),      32'd0);
      check_val("rst_error", 32'(error),     32'd0);
      check_val("rst_state", 32'(cur_state), 32'd0);
      check_val("rst_steps", 32'(steps),     32'd0);
   endtask

   // One run: optional table write in the start cycle, optional start/prog
   // poke mid-run (both must be ignored), then scoreboard compare on done.
   task automatic run(input logic [2:0] sh, input bit with_prog, input logic [3:0] pa,
                      input logic [6:0] pd, input bit poke, input logic [3:0] kill_addr);
      exp_t e, x;
      int   cnt, writes, b2b;
      bit   prev_mode, seen;
      logic [15:0] tape_now;
      @(negedge clk);
      if (with_prog) begin
         prog_we   = 1'b1;
         prog_addr = pa;
         prog_data = pd;
         ref_tbl[ridx(pa)] = pd;
      end
      e = model_run(sh);
      sb_q.push_back(e);
      start      = 1'b1;
      start_head = sh;
      @(posedge clk);
      #1;
      start   = 1'b0;
      prog_we = 1'b0;
      cnt = 0; writes = 0; b2b = 0; prev_mode = 0; seen = 0;
      while (!seen && cnt < 2000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (tape_bus.tape_mode) begin
            writes++;
            if (prev_mode) b2b++;
         end
         prev_mode = tape_bus.tape_mode;
         if (poke && cnt == 5) begin
            start      = 1'b1;
            start_head = 3'd5;
            prog_we    = 1'b1;
            prog_addr  = kill_addr;
            prog_data  = 7'd0;
         end else if (poke && cnt == 6) begin
            start   = 1'b0;
            prog_we = 1'b0;
         end
         if (done) seen = 1;
      end
      check_val("done_seen", 32'(seen), 32'd1);
      x = sb_q.pop_front();
      for (int i = 0; i < 8; i++) tape_now[2*i +: 2] = cells[i];
      check_val("latency",   32'(cnt + 1),            32'(x.latency));
      check_val("error",     32'(error),              32'(x.err));
      check_val("steps",     32'(steps),              32'(x.steps));
      check_val("head",      32'(tape_bus.tape_head), 32'(x.head));
      check_val("cur_state", 32'(cur_state),          32'(x.st));
      check_val("busy_end",  32'(busy),               32'd0);
      check_val("writes",    32'(writes),             32'(x.writes));
      check_val("mode_b2b",  32'(b2b),                32'd0);
      check_val("tape",      32'(tape_now),           32'(x.tape));
   endtask

   localparam logic [15:0] BLANK = 16'hAAAA;

   initial begin
      int nw, cnt;
      reset      = 1'b0;
      start      = 1'b0;
      start_head = 3'd0;
      prog_we    = 1'b0;
      prog_addr  = 4'd0;
      prog_data  = 7'd0;
      pre_load   = 1'b0;
      clear_ref();
      for (int i = 0; i < 8; i++) pre_cells[i] = 2'b10;
      repeat (3) @(posedge clk);
      #1 check_reset_vals();
      @(negedge clk) reset = 1'b1;

      // Empty table: undefined rule right after the first lookup.
      load_tape(BLANK);
      run(3'd2, 1'b0, 4'd0, 7'd0, 1'b0, 4'd0);

      // One-step halt: (s0,blank) -> {s3, write 01, right}.
      prog(4'b0010, 7'b1_11_01_01);
      load_tape(BLANK);
      run(3'd2, 1'b0, 4'd0, 7'd0, 1'b0, 4'd0);

      // Unary increment; blank rule written in the start cycle via alias 11.
      load_tape(16'hAA95);
      prog(4'b0001, 7'b1_00_01_01);
      run(3'd0, 1'b1, 4'b0011, 7'b1_11_01_00, 1'b0, 4'd0);

      // Left move at head 0: edge fault, or wrap to the step limit.
      prog(4'b0010, 7'b1_00_10_10);
      load_tape(BLANK);
      run(3'd0, 1'b0, 4'd0, 7'd0, 1'b0, 4'd0);

      // Ping-pong loop to the step limit; mid-run start/prog must be ignored.
      prog(4'b0010, 7'b1_01_10_01);
      prog(4'b0110, 7'b1_00_10_10);
      load_tape(BLANK);
      run(3'd2, 1'b0, 4'd0, 7'd0, 1'b1, 4'b0110);

      // Reset asserted during the WRITE cycle of step 3.
      load_tape(BLANK);
      @(negedge clk);
      start      = 1'b1;
      start_head = 3'd2;
      @(posedge clk);
      #1 start = 1'b0;
      nw  = 0;
      cnt = 0;
      while (nw < 3 && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
         if (tape_bus.tape_mode) nw++;
      end
      check_val("write3_seen", 32'(nw), 32'd3);
      #1 reset = 1'b0;
      #1 check_reset_vals();
      clear_ref();
      @(negedge clk) reset = 1'b1;

      // Fresh run after the abort.
      prog(4'b0010, 7'b1_11_01_01);
      load_tape(BLANK);
      run(3'd2, 1'b0, 4'd0, 7'd0, 1'b0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
